// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Includes a slave-response watchdog that completes hung accesses with a fault.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 34,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [3:0]            m0_wstrb,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  output logic                  m0_access_fault,
  input  logic                  m1_valid,
  input  logic [3:0]            m1_wstrb,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  m1_access_fault,
  output logic                  s_valid,
  output logic [3:0]            s_wstrb,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  input  logic                  s_ready,
  input  logic [31:0]           s_rdata,
  input  logic                  s_access_fault,
  output logic [1:0]            grant
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LIM   = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LIMIT = CW'(LIM);

  logic [1:0]    state_r;
  logic [1:0]    state_next_s;
  logic          last_m1_r;
  logic [CW-1:0] cnt_r;
  logic          serve0_s;
  logic          serve1_s;
  logic          timeout_s;
  logic          done_s;

  // Decode the current owner and whether this cycle ends the access
  always_comb begin
    serve0_s  = (state_r == SERVE0);
    serve1_s  = (state_r == SERVE1);
    timeout_s = WD_EN && (cnt_r == LIMIT);
    done_s    = (serve0_s || serve1_s) && (s_ready || timeout_s);
  end

  // Shared-port request fields follow the owner; everything is zero when idle
  always_comb begin
    grant   = {serve1_s, serve0_s};
    s_valid = serve0_s || serve1_s;
    if (serve0_s) begin
      s_wstrb = m0_wstrb;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (serve1_s) begin
      s_wstrb = m1_wstrb;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end else begin
      s_wstrb = 4'h0;
      s_addr  = '0;
      s_wdata = 32'h0;
    end
  end

  // Completion response; a watchdog expiry reports a fault with zero data
  always_comb begin
    m0_ready        = serve0_s && done_s;
    m1_ready        = serve1_s && done_s;
    m0_rdata        = (serve0_s && s_ready) ? s_rdata : 32'h0;
    m1_rdata        = (serve1_s && s_ready) ? s_rdata : 32'h0;
    m0_access_fault = serve0_s && (s_ready ? s_access_fault : timeout_s);
    m1_access_fault = serve1_s && (s_ready ? s_access_fault : timeout_s);
  end

  // Next-state: on a tie, favour whichever requester was not served last
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_next_s = last_m1_r ? SERVE0 : SERVE1;
        end else if (m0_valid) begin
          state_next_s = SERVE0;
        end else if (m1_valid) begin
          state_next_s = SERVE1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE0, SERVE1: begin
        if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, round-robin pointer and watchdog counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      last_m1_r <= 1'b1;
      cnt_r     <= '0;
    end else begin
      state_r <= state_next_s;
      if (done_s) begin
        last_m1_r <= serve1_s;
      end else begin
        last_m1_r <= last_m1_r;
      end
      if (!(serve0_s || serve1_s) || done_s) begin
        cnt_r <= '0;
      end else if (WD_EN) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int AW = 34;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          m0_valid, m1_valid;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_access_fault, m1_access_fault;
  logic          s_valid;
  logic [3:0]    s_wstrb;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic          s_ready;
  logic [31:0]   s_rdata;
  logic          s_access_fault;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_access_fault(m0_access_fault),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_access_fault(m1_access_fault),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_access_fault(s_access_fault),
    .grant(grant)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the port, how many cycles the access has run,
  // and which requester completed most recently (1 = m1 after reset).
  int owner  = -1;
  int served = 0;
  int last   = 1;
  bit pred_done, pred_r0, pred_r1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    served = 0;
    last   = 1;
  endtask

  task automatic expect_now(input string tag);
    logic [1:0]   e_g;
    logic [127:0] e_s, e_m0, e_m1;
    logic [33:0]  resp;
    e_g = 2'b00; e_s = '0; e_m0 = '0; e_m1 = '0;
    pred_done = 1'b0; pred_r0 = 1'b0; pred_r1 = 1'b0;
    if (owner >= 0) begin
      // Access ends on a slave response or in its TO-th cycle of service
      pred_done = s_ready || (served + 1 == TO);
      resp = {pred_done, (s_ready ? s_access_fault : pred_done), (s_ready ? s_rdata : 32'h0)};
      if (owner == 0) begin
        e_g = 2'b01; e_s = 128'({1'b1, m0_wstrb, m0_addr, m0_wdata}); e_m0 = 128'(resp); pred_r0 = pred_done;
      end else begin
        e_g = 2'b10; e_s = 128'({1'b1, m1_wstrb, m1_addr, m1_wdata}); e_m1 = 128'(resp); pred_r1 = pred_done;
      end
    end
    chk({tag, "_grant"}, 128'(grant), 128'(e_g));
    chk({tag, "_sport"}, 128'({s_valid, s_wstrb, s_addr, s_wdata}), e_s);
    chk({tag, "_m0"}, 128'({m0_ready, m0_access_fault, m0_rdata}), e_m0);
    chk({tag, "_m1"}, 128'({m1_ready, m1_access_fault, m1_rdata}), e_m1);
  endtask

  task automatic model_edge();
    if (!resetn) begin
      model_reset();
    end else if (owner < 0) begin
      served = 0;
      if (m0_valid && m1_valid) owner = (last == 1) ? 0 : 1;
      else if (m0_valid)        owner = 0;
      else if (m1_valid)        owner = 1;
    end else if (pred_done) begin
      last  = owner;
      owner = -1;
    end else begin
      served++;
    end
  endtask

  // One clock: check at negedge+1, advance model at posedge, return at negedge
  task automatic cyc(input string tag);
    #1;
    expect_now(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // As cyc, then requesters retire their request after seeing ready
  task automatic tick(input string tag);
    cyc(tag);
    if (pred_r0) m0_valid = 1'b0;
    if (pred_r1) m1_valid = 1'b0;
    s_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    cyc("rst");
    cyc("rst");
    resetn = 1'b1;
  endtask

  initial begin
    m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = 32'h0;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = 32'h0;
    s_ready = 1'b0; s_rdata = 32'h0; s_access_fault = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    do_reset();
    chk("reset_grant", 128'(grant), 128'(2'b00));

    // Single m0 read, slave answers three cycles after s_valid
    m0_valid = 1'b1; m0_addr = 34'h0_8000_0000; m0_wstrb = 4'h0; m0_wdata = 32'h0;
    tick("rd_idle");
    for (int i = 0; i < 3; i++) tick("rd_wait");
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF; s_access_fault = 1'b0;
    #1;
    chk("rd_data", 128'({m0_ready, m0_rdata, grant}), 128'({1'b1, 32'hDEADBEEF, 2'b01}));
    chk("rd_m1_quiet", 128'({m1_ready, m1_rdata, m1_access_fault}), 128'(0));
    tick("rd_done");
    tick("rd_after");

    // Ties from reset: m0, m1, then m0 again; a tie after m0 favours m1
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 34'h100; m1_addr = 34'h200;
    tick("tie_idle");
    chk("tie1_first", 128'(grant), 128'(2'b01));
    s_ready = 1'b1; s_rdata = 32'h1111_0000;
    tick("tie1_done");
    tick("tie1_gap");
    chk("tie1_second", 128'(grant), 128'(2'b10));
    s_ready = 1'b1;
    tick("tie1_done2");
    m0_valid = 1'b1; m1_valid = 1'b1;
    tick("tie2_idle");
    chk("tie2_first", 128'(grant), 128'(2'b01));
    s_ready = 1'b1;
    tick("tie2_done");
    m0_valid = 1'b1;
    tick("tie3_idle");
    chk("tie3_first", 128'(grant), 128'(2'b10));
    s_ready = 1'b1;
    tick("tie3_done");
    tick("tie3_gap");
    s_ready = 1'b1;
    tick("tie3_done2");

    // m1 write forwarded verbatim
    m1_valid = 1'b1; m1_wstrb = 4'hF; m1_wdata = 32'h12345678; m1_addr = 34'h1_0000_0010;
    tick("wr_idle");
    chk("wr_sport", 128'({grant, s_valid, s_wstrb, s_addr, s_wdata}),
        128'({2'b10, 1'b1, 4'hF, 34'h1_0000_0010, 32'h12345678}));
    s_ready = 1'b1; s_access_fault = 1'b0;
    #1;
    chk("wr_ready", 128'({m1_ready, m1_access_fault}), 128'(2'b10));
    tick("wr_done");

    // Watchdog: silent slave, fault in the TO-th cycle of s_valid
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 34'h3_0000_0000;
    tick("to_idle");
    for (int i = 0; i < TO - 1; i++) tick("to_wait");
    #1;
    chk("to_resp", 128'({m0_ready, m0_access_fault, m0_rdata}), 128'({1'b1, 1'b1, 32'h0}));
    tick("to_fire");
    chk("to_release", 128'(s_valid), 128'(1'b0));

    // Slave response in the watchdog cycle wins
    m0_valid = 1'b1;
    tick("tw_idle");
    for (int i = 0; i < TO - 1; i++) tick("tw_wait");
    s_ready = 1'b1; s_access_fault = 1'b0; s_rdata = 32'hCAFE0001;
    #1;
    chk("tw_resp", 128'({m0_ready, m0_access_fault, m0_rdata}), 128'({1'b1, 1'b0, 32'hCAFE0001}));
    tick("tw_done");

    // Requester withdraws while granted; access still completes
    m0_valid = 1'b1; m0_addr = 34'h44;
    tick("drop_idle");
    m0_valid = 1'b0;
    tick("drop_wait");
    s_ready = 1'b1;
    tick("drop_done");

    // Asynchronous reset in the middle of an m1 access
    m1_valid = 1'b1; m1_wstrb = 4'h3; m1_addr = 34'h2_0000_0000;
    tick("ar_idle");
    tick("ar_serve");
    s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF; s_access_fault = 1'b1;
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("ar_zero", 128'({grant, s_valid, s_wstrb, s_addr, s_wdata, m1_ready, m1_access_fault, m1_rdata}), 128'(0));
    chk("ar_m0_zero", 128'({m0_ready, m0_access_fault, m0_rdata}), 128'(0));
    @(negedge clk);
    cyc("ar_hold");
    resetn = 1'b1; s_ready = 1'b0; s_access_fault = 1'b0;
    m1_valid = 1'b0; m0_valid = 1'b1; m0_addr = 34'h55;
    tick("ar_new_idle");
    chk("ar_new_grant", 128'(grant), 128'(2'b01));
    s_ready = 1'b1;
    tick("ar_new_done");

    // Randomized traffic with periodic silent-slave windows
    for (int i = 0; i < 3000; i++) begin
      if (!m0_valid && $urandom_range(0, 2) == 0) begin
        m0_valid = 1'b1; m0_wstrb = 4'($urandom()); m0_addr = AW'({$urandom(), $urandom()}); m0_wdata = $urandom();
      end
      if (!m1_valid && $urandom_range(0, 2) == 0) begin
        m1_valid = 1'b1; m1_wstrb = 4'($urandom()); m1_addr = AW'({$urandom(), $urandom()}); m1_wdata = $urandom();
      end
      s_ready        = ((i % 250) < 40) ? 1'b0 : ($urandom_range(0, 3) == 0);
      s_rdata        = $urandom();
      s_access_fault = 1'($urandom());
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL expose parameter ADDR_WIDTH, default 34, the physical address width of all address ports.
REQ-002 SHALL expose parameter TIMEOUT_CYCLES, default 1024; the slave-response watchdog limit in cycles; 0 disables the watchdog.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 m0_valid / m1_valid  input  1  requester 0 (core, post-MMU) / requester 1 (DMA) access request; held until that requester's ready.
REQ-007 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-008 m0_addr / m1_addr  input  ADDR_WIDTH  physical address.
REQ-009 m0_wdata / m1_wdata  input  32  write data.
REQ-010 m0_ready / m1_ready  output  1  one-cycle completion pulse to that requester.
REQ-011 m0_rdata / m1_rdata  output  32  read data, valid only while that requester's ready is high.
REQ-012 m0_access_fault / m1_access_fault  output  1  fault flag, valid only while that requester's ready is high.
REQ-013 s_valid  output  1  request to the shared memory port.
REQ-014 s_wstrb / s_addr / s_wdata  output  4 / ADDR_WIDTH / 32  request fields forwarded from the granted requester.
REQ-015 s_ready  input  1  one-cycle completion pulse from memory.
REQ-016 s_rdata  input  32  memory read data.
REQ-017 s_access_fault  input  1  memory fault, sampled with s_ready.
REQ-018 grant  output  2  one-hot owner of the shared port (bit0 = m0, bit1 = m1); 0 when idle.

Function
REQ-019 SHALL implement FSM states IDLE, SERVE0, SERVE1; reset state IDLE.
REQ-020 IDLE: m0_valid only -> SERVE0; m1_valid only -> SERVE1; neither -> stay in IDLE.
REQ-021 IDLE, both valid: go to the requester not served last (round-robin); the last-served register resets to m1, so m0 wins the first tie.
REQ-022 SERVEx: s_valid=1 and grant=one-hot x; s_wstrb/s_addr/s_wdata SHALL combinationally follow requester x.
REQ-023 SERVEx with s_ready=1: assert mx_ready in the same cycle, mx_rdata=s_rdata, mx_access_fault=s_access_fault; update last-served to x; next state IDLE.
REQ-024 Latency: request sampled in IDLE at cycle N gives s_valid at N+1; s_ready at N+k gives mx_ready at N+k; the next grant starts no earlier than N+k+2.
REQ-025 Non-granted requester SHALL see ready=0, rdata=0, access_fault=0; outputs SHALL be 0 in IDLE.
REQ-026 s_ready in IDLE SHALL be ignored.
REQ-027 Watchdog counter SHALL clear in IDLE and increment each SERVEx cycle without s_ready.
REQ-028 If the counter reaches TIMEOUT_CYCLES-1 with no s_ready: pulse mx_ready=1, mx_access_fault=1, mx_rdata=0; update last-served; next state IDLE.
REQ-029 s_ready in the timeout cycle SHALL take precedence; the access completes normally with the slave fault value.
REQ-030 Requester dropping valid while granted (protocol violation): the arbiter SHALL hold SERVEx until s_ready or timeout, then pulse ready.
REQ-031 Counter width SHALL hold TIMEOUT_CYCLES without wrap; with TIMEOUT_CYCLES=0 the counter never triggers.

Reset
REQ-032 resetn low SHALL immediately force IDLE; grant, s_valid, all ready, rdata and fault outputs = 0; counter = 0; last-served = m1.
REQ-033 Reset mid-transaction SHALL abandon the slave access without a ready pulse; the first request after deassertion is arbitrated per REQ-020/021.

Verification
REQ-034 Single m0 read at 0x0_8000_0000, s_ready 3 cycles after s_valid with s_rdata=0xDEADBEEF -> m0_ready pulse with m0_rdata=0xDEADBEEF, grant=01, m1 outputs 0.
REQ-035 m0 and m1 valid together from reset -> m0 served first, then m1; second simultaneous pair -> m0 again (last-served=m1); a repeated tie with last-served=m0 -> m1 first.
REQ-036 m1 write, wstrb=0xF, wdata=0x12345678, addr=0x1_0000_0010 -> s_* match exactly while grant=10; s_ready pulse gives m1_ready=1, m1_access_fault=0.
REQ-037 TIMEOUT_CYCLES=16, s_ready never asserted -> m0_ready with access_fault=1 and rdata=0 exactly 16 cycles after s_valid rises; s_valid low the next cycle.
REQ-038 s_ready coincident with the timeout cycle, s_access_fault=0 -> normal completion with fault=0.
REQ-039 resetn pulled low mid-SERVE1 -> all outputs 0 asynchronously; no m1_ready pulse; a new m0 request after release is granted.
